// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register: hold / shift right / shift left / load,
// optional rotate, plus an autonomous burst engine that shifts N times on its own.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_LEN = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] len_clamped;

  // Returns {shifted_out_bit, new_word}; left = 1 shifts toward the MSB.
  function automatic logic [WIDTH:0] shift_word(
    input logic [WIDTH-1:0] w,
    input logic             left,
    input logic             rot,
    input logic             fill_in
  );
    logic fill;
    if (left) begin
      fill = rot ? w[WIDTH-1] : fill_in;
      return {w[WIDTH-1], w[WIDTH-2:0], fill};
    end else begin
      fill = rot ? w[0] : fill_in;
      return {w[0], fill, w[WIDTH-1:1]};
    end
  endfunction

  assign len_clamped = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;

  always_comb begin
    q_d     = q_q;
    sout_d  = sout_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (burst_start) begin
            // Direction and rotate are captured so the burst ignores later changes.
            cnt_d   = len_clamped;
            dir_d   = burst_dir;
            rot_d   = rotate;
            state_d = (len_clamped == '0) ? ST_DONE : ST_BURST;
          end else begin
            case (mode)
              MODE_RIGHT: {sout_d, q_d} = shift_word(q_q, 1'b0, rotate, sin);
              MODE_LEFT:  {sout_d, q_d} = shift_word(q_q, 1'b1, rotate, sin);
              MODE_LOAD:  q_d = d;
              default:    q_d = q_q;
            endcase
          end
        end
        ST_BURST: begin
          {sout_d, q_d} = shift_word(q_q, dir_q, rot_q, sin);
          cnt_d = cnt_q - ONE_LEN;
          if (cnt_q == ONE_LEN) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_BURST);
    done_d = (state_d == ST_DONE);
  end

  // busy/done are decoded from the next state so they leave as flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      sout_q  <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      sout_q  <= sout_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_shift_reg_univ;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          rotate = 1'b0;
  logic          sin = 1'b0;
  logic [W-1:0]  d = '0;
  logic          burst_start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          burst_dir = 1'b0;
  logic [W-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  // Model state: the word, last bit out, shifts still owed, and a pending done cycle.
  logic [W-1:0] m_q = '0;
  bit           m_sout = 1'b0;
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_dir = 1'b0;
  bit           m_rot = 1'b0;

  shift_reg_univ #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .rotate      (rotate),
    .sin         (sin),
    .d           (d),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .burst_dir   (burst_dir),
    .q           (q),
    .sout        (sout),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic shift model: dividing/multiplying by two moves bits toward bit 0 / the MSB.
  task automatic model_shift(input bit left, input bit rot, input bit fill_in);
    int unsigned w;
    bit out_bit;
    bit fill;
    w = m_q;
    if (!left) begin
      out_bit = w[0];
      fill = rot ? out_bit : fill_in;
      w = w / 2 + (fill ? (2 ** (W - 1)) : 0);
    end else begin
      out_bit = (w / (2 ** (W - 1))) % 2 == 1;
      fill = rot ? out_bit : fill_in;
      w = (w * 2) % (2 ** W) + (fill ? 1 : 0);
    end
    m_q = w[W-1:0];
    m_sout = out_bit;
  endtask

  task automatic model_step();
    int n;
    if (!en) return;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      model_shift(m_dir, m_rot, sin);
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (burst_start) begin
      n = (int'(burst_len) > W) ? W : int'(burst_len);
      m_dir = burst_dir;
      m_rot = rotate;
      m_left = n;
      if (n == 0) m_done = 1'b1;
    end else begin
      case (mode)
        2'b01:   model_shift(1'b0, rotate, sin);
        2'b10:   model_shift(1'b1, rotate, sin);
        2'b11:   m_q = d;
        default: ;
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("model_q", q, m_q);
    checkOutput("model_sout", sout, m_sout);
    checkOutput("model_busy", busy, (m_left > 0));
    checkOutput("model_done", done, m_done);
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
    #1;
    compareAll();
  end

  always @(negedge rst_n) begin
    m_q = '0;
    m_sout = 1'b0;
    m_left = 0;
    m_done = 1'b0;
    #1;
    compareAll();
  end

  task automatic applyStimulus(input bit e, input logic [1:0] m, input bit rot, input bit s,
                               input logic [W-1:0] dd, input bit bs, input logic [CW-1:0] len,
                               input bit dir);
    @(negedge clk);
    en = e;
    mode = m;
    rotate = rot;
    sin = s;
    d = dd;
    burst_start = bs;
    burst_len = len;
    burst_dir = dir;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int busy_cycles;
    int done_pulses;
    logic [W-1:0] steps [3];
    steps[0] = 8'h78;
    steps[1] = 8'h3C;
    steps[2] = 8'h1E;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_q", q, 8'h00);
    checkOutput("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 2'b11, 0, 0, 8'hA5, 0, 0, 0);
    checkOutput("load_q", q, 8'hA5);
    checkOutput("load_sout", sout, 1'b0);
    applyStimulus(1, 2'b01, 0, 1, 8'h00, 0, 0, 0);
    checkOutput("shr_q", q, 8'hD2);
    checkOutput("shr_sout", sout, 1'b1);
    applyStimulus(1, 2'b10, 1, 0, 8'h00, 0, 0, 0);
    checkOutput("rotl_q", q, 8'hA5);
    checkOutput("rotl_sout", sout, 1'b1);

    // Burst right by 3 while a load of 0xFF and a second burst_start are presented.
    applyStimulus(1, 2'b11, 0, 0, 8'hF0, 0, 0, 0);
    applyStimulus(1, 2'b00, 0, 0, 8'h00, 1, 4'd3, 0);
    checkOutput("burst3_start_busy", busy, 1'b1);
    checkOutput("burst3_start_q", q, 8'hF0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b11, 0, 0, 8'hFF, 1, 4'd5, 1);
      checkOutput("burst3_q", q, steps[i]);
      checkOutput("burst3_busy", busy, (i < 2));
      checkOutput("burst3_done", done, (i == 2));
    end
    checkOutput("burst3_sout", sout, 1'b0);
    applyStimulus(1, 2'b00, 0, 0, 8'h00, 0, 0, 0);
    checkOutput("burst3_after_done", done, 1'b0);
    checkOutput("burst3_after_q", q, 8'h1E);

    // Full rotate burst with a 2-cycle enable stall in the middle.
    applyStimulus(1, 2'b11, 0, 0, 8'h81, 0, 0, 0);
    applyStimulus(1, 2'b00, 1, 0, 8'h00, 1, 4'd8, 0);
    busy_cycles = busy ? 1 : 0;
    done_pulses = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(!(i == 3 || i == 4), 2'b00, 0, 0, 8'h00, 0, 0, 0);
      if (busy) busy_cycles++;
      if (done) done_pulses++;
      if (i == 9) checkOutput("rot8_q", q, 8'h81);
    end
    checkOutput("rot8_busy_cycles", busy_cycles, 10);
    checkOutput("rot8_done_pulses", done_pulses, 1);

    applyStimulus(1, 2'b00, 0, 0, 8'h00, 1, 4'd0, 0);
    checkOutput("len0_done", done, 1'b1);
    checkOutput("len0_busy", busy, 1'b0);
    checkOutput("len0_q", q, 8'h81);
    applyStimulus(1, 2'b00, 0, 0, 8'h00, 0, 0, 0);
    checkOutput("len0_done_clear", done, 1'b0);

    // Over-long length clamps to a full rotation.
    applyStimulus(1, 2'b00, 1, 0, 8'h00, 1, 4'd12, 1);
    repeat (8) applyStimulus(1, 2'b00, 0, 0, 8'h00, 0, 0, 0);
    checkOutput("clamp_done", done, 1'b1);
    checkOutput("clamp_q", q, 8'h81);
    applyStimulus(1, 2'b00, 0, 0, 8'h00, 0, 0, 0);

    // Reset two shifts into a length-5 left burst.
    applyStimulus(1, 2'b11, 0, 0, 8'h3C, 0, 0, 0);
    applyStimulus(1, 2'b00, 0, 1, 8'h00, 1, 4'd5, 1);
    applyStimulus(1, 2'b00, 0, 1, 8'h00, 0, 0, 0);
    applyStimulus(1, 2'b00, 0, 1, 8'h00, 0, 0, 0);
    checkOutput("abort_pre_q", q, 8'hF3);
    checkOutput("abort_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_q", q, 8'h00);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_pulses = 0;
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 2'b00, 0, 1, 8'h00, 0, 0, 0);
      if (done) done_pulses++;
      if (busy) busy_cycles++;
    end
    checkOutput("abort_no_done", done_pulses, 0);
    checkOutput("abort_idle", busy_cycles, 0);

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      en = ($urandom_range(0, 9) != 0);
      mode = 2'($urandom_range(0, 3));
      rotate = 1'($urandom_range(0, 1));
      sin = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      burst_start = ($urandom_range(0, 7) == 0);
      burst_len = 4'($urandom_range(0, 15));
      burst_dir = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the successor to the team's single-bit D flip-flop. It holds a WIDTH-bit word and supports hold, shift right, shift left and parallel load, with optional rotate. An autonomous burst engine shifts the word N times without per-cycle control. It sits wherever the design needs serialisers, deserialisers or programmable bit alignment.

## Interface
- WIDTH, 8, register width in bits; legal range is 2 to 64.
- CNT_W, $clog2(WIDTH+1), width of the burst counter; derived, never overridden.

- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- en  input  1  global clock enable; low freezes all state, including the burst counter.
- mode  input  2  00 hold, 01 shift right (toward bit 0), 10 shift left, 11 parallel load.
- rotate  input  1  1 = the shifted-out bit re-enters at the opposite end; 0 = sin enters.
- sin  input  1  serial fill bit.
- d  input  WIDTH  parallel load data.
- burst_start  input  1  request an automatic burst; sampled only when idle.
- burst_len  input  CNT_W  number of shifts in the burst, 0 to WIDTH.
- burst_dir  input  1  burst direction: 0 = right, 1 = left.
- q  output  WIDTH  register contents.
- sout  output  1  registered: the last bit shifted out.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

## Operation
- Reset values: q = 0, sout = 0, busy = 0, done = 0, FSM = IDLE, counter = 0.
- All state updates happen on a rising clk edge with en = 1. With en = 0, nothing changes, and done holds its value.
- IDLE with burst_start = 0 performs the manual mode operation:
  - Shift right: q <= {fill, q[WIDTH-1:1]} and sout <= q[0]. fill is q[0] if rotate = 1, otherwise sin.
  - Shift left: q <= {q[WIDTH-2:0], fill} and sout <= q[WIDTH-1]. fill is q[WIDTH-1] if rotate = 1, otherwise sin.
  - Load: q <= d; sout is unchanged.
  - Hold: no change.
- IDLE with burst_start = 1 latches burst_len, burst_dir and rotate, and performs no mode operation that cycle.
  - burst_len != 0: the FSM goes to BURST.
  - burst_len = 0: the FSM goes to DONE with no shift.
  - burst_len > WIDTH: clamped to WIDTH.
- BURST performs one shift per enabled cycle, in the latched direction, with the latched rotate setting.
  - Fill is the live sin when rotate is not latched.
  - mode, d and burst_start are ignored.
  - The counter decrements each shift. The shift that takes it to 0 also moves the FSM to DONE.
- DONE lasts one cycle, then the FSM returns to IDLE. In DONE, mode operations are ignored and burst_start is ignored.
- busy = 1 exactly while the FSM is in BURST.
- done = 1 exactly while the FSM is in DONE.
- Reset asserted mid-burst aborts the burst immediately: all outputs return to their reset values, and no done pulse is produced.
- A full-width rotate burst (len = WIDTH) returns q to its starting value.

## Timing
- Manual operations: q and sout update on the first rising edge at which they are sampled, giving 1-cycle latency.
- Burst with burst_start sampled at edge k and length N ≥ 1:
  - Shifts occur at edges k+1 … k+N.
  - busy is high from edge k to edge k+N.
  - done is high from edge k+N to edge k+N+1.
  - The next burst_start or mode operation is accepted at edge k+N+1.
- Burst with N = 0: done is high from edge k to edge k+1, and busy never rises.
- Cycles with en low stretch the burst 1:1; the shift count is unaffected.
- Outputs are glitch-free register outputs; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and load, WIDTH = 8: hold rst_n = 0, then release, then apply mode = 11 with d = 0xA5. Required: q = 0x00 during reset, q = 0xA5 one cycle after the load, and sout = 0.
- Manual shifts from q = 0xA5:
  - Shift right, rotate = 0, sin = 1: q = 0xD2, sout = 1.
  - Shift left, rotate = 1: from 0xD2, q = 0xA5, sout = 1.
- Burst right of length 3, rotate = 0, sin = 0, from q = 0xF0: busy is high for 3 cycles, q steps 0x78 → 0x3C → 0x1E, sout = 0, and done pulses for one cycle right after the third shift.
- Burst rotate of length 8 from q = 0x81, with en low for 2 cycles mid-burst: q ends at 0x81, busy lasts 10 cycles, and done pulses once. Burst of length 0: done pulses, busy stays 0, and q is unchanged.
- mode = 11 with d = 0xFF held during the burst is ignored. A burst_start issued while busy is ignored.
- Reset mid-burst: assert rst_n low after 2 shifts of a length-5 burst. Required: q, busy and done go to 0 immediately and asynchronously, no done pulse occurs after release, and the FSM is IDLE.
